// File: rtl/branch_ctrl_pkg.sv
// Shared types for the decode-stage branch predictor and its resolution controller.
package branch_ctrl_pkg;

    typedef logic [63:0] word_t;
    typedef logic        u1;

    typedef struct packed {
        word_t pc;
        u1     taken;
        word_t target;
    } bp_entry_t;

    typedef enum logic [0:0] {
        BP_RUN      = 1'b0,
        BP_REDIRECT = 1'b1
    } bpctrl_state_t;

    localparam word_t INSN_BYTES = 64'd4;

    // Not-taken branches resume at the next sequential instruction.
    function automatic word_t fallthrough_pc(input word_t pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/branch_ctrl_fifo.sv
// In-order tracker of predicted branches; clear empties it in one cycle.
module bp_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          clear,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A full tracker still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Checks decode's branch predictions against execute and sequences mispredict recovery.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic [63:0] pred_pc,
    input  logic        pred_taken,
    input  logic [63:0] pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [63:0] res_target,
    input  logic        redirect_ready,
    output logic        full,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        flush_fd,
    output logic        upd_valid,
    output logic        upd_taken,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt,
    output logic        err
);

    localparam int CW = $clog2(DEPTH) + 1;

    bpctrl_state_t state;
    bp_entry_t     head;
    bp_entry_t     push_entry;
    logic [CW-1:0] count;
    logic          in_run;
    logic          empty;
    logic          legal_res;
    logic          head_mis;
    logic          mispred;
    logic          fifo_push;
    logic          fifo_pop;
    logic          err_set;
    word_t         correct_pc;

    assign in_run     = (state == BP_RUN);
    assign empty      = (count == '0);
    assign legal_res  = in_run && res_valid && !empty;
    assign head_mis   = (res_taken != head.taken) || (res_taken && (res_target != head.target));
    assign mispred    = legal_res && head_mis;
    assign correct_pc = res_taken ? res_target : fallthrough_pc(head.pc);

    // A push alongside a mispredicting pop is wrong-path and is dropped by the clear.
    assign fifo_push  = in_run && pred_valid && !mispred;
    assign fifo_pop   = legal_res && !mispred;
    assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

    assign err_set = (!in_run && res_valid)
                   || (in_run && res_valid && empty)
                   || (in_run && pred_valid && full && !legal_res);

    assign redirect_valid = (state == BP_REDIRECT);

    bp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (bp_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (mispred),
        .head      (head),
        .count     (count),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BP_RUN;
            redirect_pc <= '0;
            flush_fd    <= 1'b0;
            upd_valid   <= 1'b0;
            upd_taken   <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            err         <= 1'b0;
        end else begin
            flush_fd  <= mispred;
            upd_valid <= legal_res;
            upd_taken <= legal_res && res_taken;
            if (legal_res) branch_cnt <= branch_cnt + 32'd1;
            if (err_set)   err        <= 1'b1;
            case (state)
                BP_RUN: begin
                    if (mispred) begin
                        state       <= BP_REDIRECT;
                        redirect_pc <= correct_pc;
                        mispred_cnt <= mispred_cnt + 32'd1;
                    end
                end
                BP_REDIRECT: begin
                    if (redirect_ready) state <= BP_RUN;
                end
                default: state <= BP_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed vector bench for branch_ctrl with DEPTH=4.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pred_valid = 1'b0;
    logic [63:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [63:0] pred_target = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [63:0] res_target = '0;
    logic        redirect_ready = 1'b0;
    logic        full;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush_fd;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [63:0] ppc;
        logic        pt;
        logic [63:0] ptg;
        logic        rs;
        logic        rt;
        logic [63:0] rtg;
        logic        rdy;
        logic        e_full;
        logic        e_rdv;
        logic [63:0] e_rpc;
        logic        e_fl;
        logic        e_uv;
        logic        e_ut;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] R1 = 64'h8000_0104;

    branch_ctrl #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .redirect_ready (redirect_ready),
        .full           (full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_fd       (flush_fd),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic void add(
        input logic rst, pv, input logic [63:0] ppc, input logic pt, input logic [63:0] ptg,
        input logic rs, rt, input logic [63:0] rtg, input logic rdy,
        input logic e_full, e_rdv, input logic [63:0] e_rpc, input logic e_fl, e_uv, e_ut,
        input logic [31:0] e_bc, e_mc, input logic e_err);
        vec_t v;
        v = '{rst, pv, ppc, pt, ptg, rs, rt, rtg, rdy,
              e_full, e_rdv, e_rpc, e_fl, e_uv, e_ut, e_bc, e_mc, e_err};
        vecs.push_back(v);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial begin
        int flushes;
        int waited;

        //   rst pv ppc            pt ptg            rs rt rtg            rdy  full rdv rpc           fl uv ut bc mc err
        add(1, 0, 0,              0, 0,             0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 0, 0, 0);
        add(0, 1, 64'h8000_0000,  1, 64'h8000_0040, 0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 0, 0, 0);
        add(0, 0, 0,              0, 0,             1, 1, 64'h8000_0040, 0,   0, 0, 0,             0, 1, 1, 1, 0, 0);
        add(0, 0, 0,              0, 0,             0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 1, 0, 0);
        add(0, 1, 64'h8000_0100,  1, 64'h8000_0200, 0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 1, 0, 0);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 1, R1,            1, 1, 0, 2, 1, 0);
        add(0, 1, 64'hdead_0000,  1, 64'hbeef,      0, 0, 0,             0,   0, 1, R1,            0, 0, 0, 2, 1, 0);
        add(0, 1, 64'hdead_0004,  0, 0,             0, 0, 0,             0,   0, 1, R1,            0, 0, 0, 2, 1, 0);
        add(0, 0, 0,              0, 0,             0, 0, 0,             0,   0, 1, R1,            0, 0, 0, 2, 1, 0);
        add(0, 0, 0,              0, 0,             0, 0, 0,             1,   0, 0, R1,            0, 0, 0, 2, 1, 0);
        // fill to DEPTH, overflow push, then push+pop while full
        add(0, 1, 64'h1000,       0, 0,             0, 0, 0,             0,   0, 0, R1,            0, 0, 0, 2, 1, 0);
        add(0, 1, 64'h1010,       0, 0,             0, 0, 0,             0,   0, 0, R1,            0, 0, 0, 2, 1, 0);
        add(0, 1, 64'h1020,       0, 0,             0, 0, 0,             0,   0, 0, R1,            0, 0, 0, 2, 1, 0);
        add(0, 1, 64'h1030,       0, 0,             0, 0, 0,             0,   1, 0, R1,            0, 0, 0, 2, 1, 0);
        add(0, 1, 64'h1040,       0, 0,             0, 0, 0,             0,   1, 0, R1,            0, 0, 0, 2, 1, 1);
        add(0, 1, 64'h1050,       0, 0,             1, 0, 0,             0,   1, 0, R1,            0, 1, 0, 3, 1, 1);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 0, R1,            0, 1, 0, 4, 1, 1);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 0, R1,            0, 1, 0, 5, 1, 1);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 0, R1,            0, 1, 0, 6, 1, 1);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 0, R1,            0, 1, 0, 7, 1, 1);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 0, R1,            0, 0, 0, 7, 1, 1);
        // wrong target on a taken branch
        add(0, 1, 64'h2000,       1, 64'h100,       0, 0, 0,             0,   0, 0, R1,            0, 0, 0, 7, 1, 1);
        add(0, 0, 0,              0, 0,             1, 1, 64'h200,       0,   0, 1, 64'h200,       1, 1, 1, 8, 2, 1);
        add(0, 0, 0,              0, 0,             0, 0, 0,             1,   0, 0, 64'h200,       0, 0, 0, 8, 2, 1);
        // reset in the second cycle of a redirect
        add(0, 1, 64'h3000,       0, 0,             0, 0, 0,             0,   0, 0, 64'h200,       0, 0, 0, 8, 2, 1);
        add(0, 0, 0,              0, 0,             1, 1, 64'h3100,      0,   0, 1, 64'h3100,      1, 1, 1, 9, 3, 1);
        add(0, 0, 0,              0, 0,             0, 0, 0,             0,   0, 1, 64'h3100,      0, 0, 0, 9, 3, 1);
        add(1, 0, 0,              0, 0,             0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 0, 0, 0);
        add(0, 1, 64'h4000,       1, 64'h4040,      0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 0, 0, 0);
        add(0, 0, 0,              0, 0,             1, 1, 64'h4040,      0,   0, 0, 0,             0, 1, 1, 1, 0, 0);
        add(0, 0, 0,              0, 0,             1, 1, 64'h4040,      0,   0, 0, 0,             0, 0, 0, 1, 0, 1);
        // push with a mispredicting pop, then minimum-gap restart
        add(0, 1, 64'h5000,       0, 0,             0, 0, 0,             0,   0, 0, 0,             0, 0, 0, 1, 0, 1);
        add(0, 1, 64'h5100,       1, 64'haaaa,      1, 1, 64'h5800,      0,   0, 1, 64'h5800,      1, 1, 1, 2, 1, 1);
        add(0, 1, 64'h6000,       1, 64'h9999,      0, 0, 0,             1,   0, 0, 64'h5800,      0, 0, 0, 2, 1, 1);
        add(0, 1, 64'h7000,       0, 0,             0, 0, 0,             0,   0, 0, 64'h5800,      0, 0, 0, 2, 1, 1);
        add(0, 0, 0,              0, 0,             1, 0, 0,             0,   0, 0, 64'h5800,      0, 1, 0, 3, 1, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            pred_valid     = vecs[i].pv;
            pred_pc        = vecs[i].ppc;
            pred_taken     = vecs[i].pt;
            pred_target    = vecs[i].ptg;
            res_valid      = vecs[i].rs;
            res_taken      = vecs[i].rt;
            res_target     = vecs[i].rtg;
            redirect_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d full", i), 64'(full), 64'(vecs[i].e_full));
            chk($sformatf("v%0d redirect_valid", i), 64'(redirect_valid), 64'(vecs[i].e_rdv));
            chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d flush_fd", i), 64'(flush_fd), 64'(vecs[i].e_fl));
            chk($sformatf("v%0d upd_valid", i), 64'(upd_valid), 64'(vecs[i].e_uv));
            if (vecs[i].e_uv)
                chk($sformatf("v%0d upd_taken", i), 64'(upd_taken), 64'(vecs[i].e_ut));
            chk($sformatf("v%0d branch_cnt", i), 64'(branch_cnt), 64'(vecs[i].e_bc));
            chk($sformatf("v%0d mispred_cnt", i), 64'(mispred_cnt), 64'(vecs[i].e_mc));
            chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].e_err));
        end

        // Redirect held by a randomly stalling fetch: one flush, stable PC, bounded wait.
        @(negedge clk);
        res_valid   = 1'b0;
        pred_valid  = 1'b1;
        pred_pc     = 64'h8000;
        pred_taken  = 1'b0;
        pred_target = '0;
        @(negedge clk);
        pred_valid     = 1'b0;
        res_valid      = 1'b1;
        res_taken      = 1'b1;
        res_target     = 64'hc000;
        redirect_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("seq redirect_valid", 64'(redirect_valid), 64'd1);
        flushes = 0;
        waited  = 0;
        while (redirect_valid && waited < 20) begin
            if (flush_fd) flushes++;
            chk("seq redirect_pc", redirect_pc, 64'hc000);
            @(negedge clk);
            res_valid      = 1'b0;
            redirect_ready = (waited >= 6) ? 1'b1 : ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            waited++;
        end
        res_valid      = 1'b0;
        redirect_ready = 1'b0;
        chk("seq redirect released", 64'(redirect_valid), 64'd0);
        chk("seq flush pulses", 64'(flushes), 64'd1);
        chk("seq flush after release", 64'(flush_fd), 64'd0);
        chk("seq mispred_cnt", 64'(mispred_cnt), 64'd2);
        chk("seq branch_cnt", 64'(branch_cnt), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution controller for the decode-stage predictor. It tracks every branch or jump that decode predicts and checks each one against the outcome reported by execute. On a mispredict it sequences the front-end recovery: it flushes the wrong-path branches it is holding, drives a redirect handshake to fetch and stops tracking until fetch accepts the redirect. It also issues one training update per resolved branch to the 2-bit predictor and keeps branch and mispredict counters for perf.

## Interface
- DEPTH, 4: number of in-flight predicted branches tracked; power of two, 2..8.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- pred_valid  in  1  decode has a predicted control-flow instruction this cycle.
- pred_pc  in  64  PC of that instruction.
- pred_taken  in  1  predicted direction.
- pred_target  in  64  predicted target; ignored when pred_taken=0.
- res_valid  in  1  execute resolves the oldest tracked branch this cycle.
- res_taken  in  1  actual direction.
- res_target  in  64  actual target.
- redirect_ready  in  1  fetch accepts the redirect.
- full  out  1  tracker holds DEPTH entries; decode must stall.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  64  correct PC; stable while redirect_valid=1.
- flush_fd  out  1  one-cycle pulse that kills the fetch and decode stages.
- upd_valid  out  1  one-cycle training pulse to the predictor.
- upd_taken  out  1  direction to train toward.
- branch_cnt  out  32  number of resolved branches.
- mispred_cnt  out  32  number of mispredicts.
- err  out  1  sticky protocol-violation flag.

## Operation
- Tracker: FIFO of bp_entry_t {pc, taken, target} with a count register of width $clog2(DEPTH)+1.
  - In state RUN, pred_valid pushes pred_pc, pred_taken and pred_target.
  - res_valid pops the head and compares it with the resolved outcome.
- Mispredict: res_taken != head.taken, or (res_taken=1 and res_target != head.target).
- Correct PC: res_target if res_taken=1, otherwise head.pc + 64'd4. Addition is modulo 2^64.
- Training: every res_valid with a non-empty tracker gives upd_valid=1 and upd_taken=res_taken on the next cycle, whether or not it was a mispredict.
- FSM states RUN and REDIRECT:
  - RUN → REDIRECT on a mispredict. The same edge does all of the following:
    - clear the whole tracker (count=0, pointers reset);
    - latch redirect_pc;
    - pulse flush_fd;
    - increment mispred_cnt.
  - REDIRECT: redirect_valid=1 and redirect_pc is held. pred_valid is ignored, with no push and no err, because those are wrong-path instructions. res_valid in this state sets err.
  - REDIRECT → RUN on the first edge where redirect_valid and redirect_ready are both 1. The tracker starts empty.
- branch_cnt increments on every legal resolve. Both counters wrap at 2^32.
- Boundary cases:
  - Push and pop in the same cycle without a mispredict: both happen and count is unchanged. This is legal even when full=1.
  - Push and a mispredicting pop in the same cycle: the push is discarded because it is wrong-path.
  - Push while full with no pop in the same cycle: push dropped, err set.
  - res_valid while the tracker is empty: ignored, err set, no update pulse.
  - reset in any state: back to RUN with all outputs 0, counters 0, err 0 and the tracker empty, including when reset arrives in the middle of a redirect.

## Timing
- Reset values: every output is 0. full=0. redirect_pc=0.
- full is combinational from count: full = (count == DEPTH).
- Decision latency: 1 cycle. For res_valid at edge N, upd_valid, flush_fd and redirect_valid are all high in cycle N+1.
- flush_fd is high for exactly one cycle per mispredict.
- redirect_valid stays high from cycle N+1 until the handshake cycle, inclusive. It is low on the cycle after the handshake.
- Minimum mispredict-to-next-push gap: 2 cycles, which happens when redirect_ready is already 1.
- No combinational path from res_* to any output.

## Structure
- pipes package gains:
  - bp_entry_t, a packed struct {word_t pc; u1 taken; word_t target}.
  - bpctrl_state_t, an enum {BP_RUN, BP_REDIRECT}.
- Sub-module bp_fifo: parameterised DEPTH and entry type. It provides push, pop, clear, head, count and full.
- branch_ctrl contains the FSM, the compare logic, the counters and the err logic.

## Test plan
- Push pc=0x8000_0000, taken=1, target=0x8000_0040, then resolve taken=1 with target 0x8000_0040 → next cycle upd_valid=1, upd_taken=1, no flush, branch_cnt=1, mispred_cnt=0.
- Push pc=0x8000_0100, taken=1, then resolve taken=0 → next cycle flush_fd=1 and redirect_valid=1 with redirect_pc=0x8000_0104. Hold redirect_ready=0 for 3 cycles → redirect_pc held and pred_valid ignored. Raise redirect_ready → RUN, tracker empty, mispred_cnt=1.
- Make four pushes with DEPTH=4 → full=1. A fifth push alone → dropped and err=1. A push and a correct resolve in the same cycle → count stays 4.
- Push taken=1 with target 0x100, then resolve taken=1 with target 0x200 → redirect_pc=0x200 and a mispredict counted.
- Assert reset in the second cycle of REDIRECT → next cycle all outputs 0, and a following push/resolve pair behaves normally.
- Pulse res_valid with the tracker empty → err=1, no upd_valid, and branch_cnt unchanged.
